input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end stage feeding the ASCII ALU from the board's raw switches and push-button. Synchronises the 3-bit operand switches and 4-bit opcode switches, debounces the go button, and captures a stable operand/opcode set on each confirmed press. Converts the abbreviated opcode to the 11-bit one-hot `op_code` and presents it with a single valid/ready `go` handshake toward the ALU.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable samples required to accept a button edge (10 ms at 100 MHz); minimum 2.
- `SYNC_STAGES`, 2: flip-flop depth of every input synchroniser; minimum 2.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `a_short` in 3: raw operand A switches, asynchronous.
- `b_short` in 3: raw operand B switches, asynchronous.
- `op_code_abbreviated` in 4: raw opcode switches, asynchronous.
- `go_btn` in 1: raw go push-button, active-high, bouncy.
- `alu_ready` in 1: ALU accepts a request when high.
- `a` out 8: captured A, zero-extended.
- `b` out 8: captured B, zero-extended.
- `op_code` out 11: captured one-hot opcode.
- `go` out 1: request valid.
- `op_err` out 1: captured opcode was illegal. Present only with `INPUT_COND_OP_ERR_EN`.

## Operation
- All asynchronous inputs pass through `SYNC_STAGES` flops before use.
- Debounce FSM on the synchronised button:
  - IDLE: counter 0. Button high -> PRESS_WAIT.
  - PRESS_WAIT: count while high; low -> IDLE, counter cleared. Counter reaching `DEBOUNCE_CYCLES` -> capture event, go to HELD.
  - HELD: button low -> RELEASE_WAIT.
  - RELEASE_WAIT: count while low; high -> HELD, counter cleared. Reaching `DEBOUNCE_CYCLES` -> IDLE.
- Capture event with `go` low:
  - `a` <= {5'b0, sync a_short}; `b` <= {5'b0, sync b_short}.
  - `op_code` <= one-hot bit n for abbreviated code n, 0..8: 0 add, 1 sub, 2 mul, 3 div, 4 RGB, 5 hi, 6 stopwatch, 7 VGA, 8 rxn.
  - Codes 9..15 give `op_code` = 0 and `op_err` = 1; legal codes give `op_err` = 0.
  - `go` <= 1.
- Capture event with `go` high: press dropped; `a`, `b`, `op_code` and `go` unchanged. FSM still enters HELD.
- Handshake: `go` stays high, with outputs frozen, until an edge sampling `go` and `alu_ready` both high. `go` then falls the next cycle.
- Switch changes between captures never reach the outputs.
- Holding the button produces exactly one request. A new request needs a full release then a new press.

## Timing
- Reset, asynchronous assert, active low: FSM IDLE, counter 0, synchronisers 0. `a` = 0, `b` = 0, `op_code` = 0, `go` = 0, `op_err` = 0.
- Reset release takes effect on the first clock edge after `reset` goes high.
- Latency: with `go_btn` held steadily high, `go` rises exactly `SYNC_STAGES + DEBOUNCE_CYCLES + 1` edges after the first edge that samples it high.
- Captured values are visible on the same edge `go` rises.
- With `alu_ready` already high, `go` is high for exactly 1 cycle.
- Reset mid-handshake or mid-count: request abandoned, all state returns to reset values.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`; the counter saturates and never wraps.

## Configuration
- `INPUT_COND_OP_ERR_EN` defined: `op_err` port and its register exist, behaving as described above.
- `INPUT_COND_OP_ERR_EN` undefined: no `op_err` port. Illegal codes still give `op_code` = 0 and still raise `go`.

## Structure
- Package `input_cond_pkg`:
  - `OP_W` = 11, `NUM_OPS` = 9, `OPND_W` = 8.
  - Named one-hot constants `OP_ADD` … `OP_RXN`.
  - Debounce state enum.
- Sub-module `btn_debounce`: synchroniser, FSM and counter. It outputs a one-cycle `press` pulse.
- The top level holds the switch synchronisers, the capture registers and the handshake.

## Test plan
- Run with `DEBOUNCE_CYCLES`=8 and `SYNC_STAGES`=2.
- Press, no bounce: a_short=5, b_short=3, op=2, held 20 cycles, alu_ready=1 -> `go` high for 1 cycle at edge 11. Outputs a=8'h05, b=8'h03, op_code=11'b00000000100.
- Bounce: go_btn toggles every 3 cycles for 15 cycles, then high for 12 -> exactly one `go`, 11 edges after the final rise.
- Stall: alu_ready=0 for 30 cycles after capture; switches change to a=7, op=0 -> `go` stays high and outputs stay a=5, op=mul. `go` clears the cycle after alu_ready=1.
- Dropped press: second full press while `go` is pending -> outputs unchanged, only one handshake completes.
- Illegal opcode: op=12, press -> op_code=0, `go`=1, `op_err`=1 (macro on).
- Reset: assert reset mid-PRESS_WAIT and again while `go` is high -> all outputs 0 immediately, no `go` after release until a fresh press.

Source files
------------

// File: rtl/input_cond_pkg.sv
// input_cond_pkg: widths, one-hot ALU opcodes and debounce states shared by input_conditioner.
package input_cond_pkg;
  localparam int OP_W    = 11;
  localparam int NUM_OPS = 9;
  localparam int OPND_W  = 8;
  localparam int SW_W    = 3;
  localparam int OPC_W   = 4;
  localparam logic [OP_W-1:0] OP_ADD       = 11'b000_0000_0001;
  localparam logic [OP_W-1:0] OP_SUB       = 11'b000_0000_0010;
  localparam logic [OP_W-1:0] OP_MUL       = 11'b000_0000_0100;
  localparam logic [OP_W-1:0] OP_DIV       = 11'b000_0000_1000;
  localparam logic [OP_W-1:0] OP_RGB       = 11'b000_0001_0000;
  localparam logic [OP_W-1:0] OP_HI        = 11'b000_0010_0000;
  localparam logic [OP_W-1:0] OP_STOPWATCH = 11'b000_0100_0000;
  localparam logic [OP_W-1:0] OP_VGA       = 11'b000_1000_0000;
  localparam logic [OP_W-1:0] OP_RXN       = 11'b001_0000_0000;
  // Codes past the last legal opcode decode to no operation at all.
  localparam logic [OP_W-1:0] OP_LUT [16] = '{
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_RGB, OP_HI, OP_STOPWATCH, OP_VGA, OP_RXN,
    11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0
  };
  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_HELD,
    DB_RELEASE_WAIT
  } db_state_e;
  function automatic logic [OP_W-1:0] op_decode(input logic [OPC_W-1:0] code);
    return OP_LUT[code];
  endfunction
  function automatic logic op_illegal(input logic [OPC_W-1:0] code);
    return code >= OPC_W'(NUM_OPS);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a bouncy button and emits a one-cycle o_press per accepted press.
module btn_debounce
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [CNT_W-1:0]       w_cnt_inc;
  db_state_e              r_state;
  db_state_e              w_state_next;
  logic                   w_btn;
  assign w_btn     = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= '0;
      r_state <= DB_IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end
  // The edge that leaves IDLE/HELD is not counted; the wait states need DEBOUNCE_CYCLES more.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    o_press      = 1'b0;
    unique case (r_state)
      DB_IDLE:
        w_state_next = w_btn ? DB_PRESS_WAIT : DB_IDLE;
      DB_PRESS_WAIT:
        if (!w_btn) begin
          w_state_next = DB_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = DB_HELD;
          o_press      = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      DB_HELD:
        w_state_next = w_btn ? DB_HELD : DB_RELEASE_WAIT;
      DB_RELEASE_WAIT:
        if (w_btn) begin
          w_state_next = DB_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = DB_IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      default:
        w_state_next = DB_IDLE;
    endcase
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronised switches + debounced go button -> one captured ALU request with go handshake.
// Optional INPUT_COND_OP_ERR_EN adds the op_err output flagging an illegal captured opcode.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SW_W-1:0]   a_short,
  input  logic [SW_W-1:0]   b_short,
  input  logic [OPC_W-1:0]  op_code_abbreviated,
  input  logic              go_btn,
  input  logic              alu_ready,
  output logic [OPND_W-1:0] a,
  output logic [OPND_W-1:0] b,
  output logic [OP_W-1:0]   op_code,
  output logic              go
`ifdef INPUT_COND_OP_ERR_EN
  ,
  output logic              op_err
`endif
);
  localparam int SWB_W = 2 * SW_W + OPC_W;
  logic [SYNC_STAGES-1:0][SWB_W-1:0] r_sw_sync;
  logic [SW_W-1:0]   w_a;
  logic [SW_W-1:0]   w_b;
  logic [OPC_W-1:0]  w_opc;
  logic              w_press;
  logic              w_capture;
  logic [OPND_W-1:0] r_a;
  logic [OPND_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic              r_go;
  assign {w_a, w_b, w_opc} = r_sw_sync[SYNC_STAGES-1];
  // A press arriving while a request is pending is dropped.
  assign w_capture = w_press && !r_go;
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (go_btn),
    .o_press(w_press)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_sync <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_go      <= 1'b0;
    end else begin
      r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], {a_short, b_short, op_code_abbreviated}};
      if (w_capture) begin
        r_a  <= OPND_W'(w_a);
        r_b  <= OPND_W'(w_b);
        r_op <= op_decode(w_opc);
      end
      r_go <= r_go ? !alu_ready : w_press;
    end
  end
  assign a       = r_a;
  assign b       = r_b;
  assign op_code = r_op;
  assign go      = r_go;
`ifdef INPUT_COND_OP_ERR_EN
  logic r_op_err;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_op_err <= 1'b0;
    else if (w_capture) r_op_err <= op_illegal(w_opc);
  end
  assign op_err = r_op_err;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized + directed bench against a run-length debounce/handshake reference model.
module tb_input_conditioner;
  localparam int D = 8;
  localparam int S = 2;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  a_short;
  logic [2:0]  b_short;
  logic [3:0]  op_ab;
  logic        go_btn;
  logic        alu_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [10:0] op_code;
  logic        go;
`ifdef INPUT_COND_OP_ERR_EN
  logic        op_err;
`endif
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;

  input_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk                (clk),
    .reset              (reset),
    .a_short            (a_short),
    .b_short            (b_short),
    .op_code_abbreviated(op_ab),
    .go_btn             (go_btn),
    .alu_ready          (alu_ready),
    .a                  (a),
    .b                  (b),
    .op_code            (op_code),
    .go                 (go)
`ifdef INPUT_COND_OP_ERR_EN
    ,
    .op_err             (op_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: the accepted button level flips after D+1 consecutive synced samples
  // that disagree with it; a flip to 1 is a press.
  logic [S-1:0]       m_bh;
  logic [S-1:0][9:0]  m_sh;
  int                 m_run;
  int                 m_run_n;
  logic               m_acc;
  logic               m_s;
  logic               m_press;
  logic [3:0]         m_code;
  logic               m_go;
  logic [7:0]         m_a;
  logic [7:0]         m_b;
  logic [10:0]        m_op;
  logic               m_err;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_bh  <= '0;
      m_sh  <= '0;
      m_run <= 0;
      m_acc <= 1'b0;
      m_go  <= 1'b0;
      m_a   <= '0;
      m_b   <= '0;
      m_op  <= '0;
      m_err <= 1'b0;
    end else begin
      m_s     = m_bh[S-1];
      m_run_n = (m_s != m_acc) ? m_run + 1 : 0;
      m_press = m_s && (m_run_n == D + 1);
      m_code  = m_sh[S-1][3:0];
      m_bh  <= {m_bh[S-2:0], go_btn};
      m_sh  <= {m_sh[S-2:0], {a_short, b_short, op_ab}};
      m_run <= (m_run_n == D + 1) ? 0 : m_run_n;
      if (m_run_n == D + 1) m_acc <= m_s;
      if (m_go) begin
        m_go <= !alu_ready;
      end else if (m_press) begin
        m_go  <= 1'b1;
        m_a   <= {5'b0, m_sh[S-1][9:7]};
        m_b   <= {5'b0, m_sh[S-1][6:4]};
        m_op  <= (m_code < 4'd9) ? 11'(32'd1 << m_code) : 11'd0;
        m_err <= m_code >= 4'd9;
      end
    end
  end

  always @(negedge clk) begin
    check("m_go", go, m_go);
    check("m_a", a, m_a);
    check("m_b", b, m_b);
    check("m_op", op_code, m_op);
`ifdef INPUT_COND_OP_ERR_EN
    check("m_err", op_err, m_err);
`endif
  end

  int pulses;
  int at;
  initial begin
    reset = 1'b1; a_short = '0; b_short = '0; op_ab = '0; go_btn = 1'b0; alu_ready = 1'b0;
    #2 reset = 1'b0;
    tick(3);
    check("rst_go", go, 0);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_op", op_code, 0);
    reset = 1'b1;
    tick(2);
    // clean press, ALU ready
    a_short = 3'd5; b_short = 3'd3; op_ab = 4'd2; alu_ready = 1'b1; go_btn = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      check("lat_go", go, e == 11);
      if (e == 11) begin
        check("cap_a", a, 8'h05);
        check("cap_b", b, 8'h03);
        check("cap_op", op_code, 11'b00000000100);
      end
    end
    go_btn = 1'b0;
    tick(20);
    // bouncing press
    pulses = 0; at = 0;
    for (int i = 0; i < 27; i++) begin
      go_btn = (i < 15) ? 1'((i / 3) % 2) : 1'b1;
      tick(1);
      if (go) begin
        pulses++;
        at = i - 14;
      end
    end
    check("bounce_pulses", pulses, 1);
    check("bounce_lat", at, 11);
    go_btn = 1'b0;
    tick(20);
    // stall with switch changes and a dropped second press
    alu_ready = 1'b0; a_short = 3'd5; b_short = 3'd3; op_ab = 4'd2; go_btn = 1'b1;
    tick(11);
    check("stall_rise", go, 1);
    go_btn = 1'b0;
    tick(12);
    a_short = 3'd7; op_ab = 4'd0; go_btn = 1'b1;
    tick(12);
    go_btn = 1'b0;
    tick(12);
    check("stall_go", go, 1);
    check("stall_a", a, 8'h05);
    check("stall_op", op_code, 11'b00000000100);
    alu_ready = 1'b1;
    tick(1);
    check("stall_clear", go, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (go) pulses++;
    end
    check("dropped_press", pulses, 0);
    // illegal opcode
    alu_ready = 1'b0; a_short = 3'd1; b_short = 3'd2; op_ab = 4'd12; go_btn = 1'b1;
    tick(11);
    check("ill_go", go, 1);
    check("ill_op", op_code, 0);
    check("ill_a", a, 8'h01);
`ifdef INPUT_COND_OP_ERR_EN
    check("ill_err", op_err, 1);
`endif
    alu_ready = 1'b1; go_btn = 1'b0;
    tick(20);
    // reset mid-count
    go_btn = 1'b1;
    tick(5);
    reset = 1'b0;
    #1;
    check("rst_mid_go", go, 0);
    check("rst_mid_a", a, 0);
    go_btn = 1'b0;
    tick(2);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (go) pulses++;
    end
    check("rst_mid_quiet", pulses, 0);
    // reset while go pending
    alu_ready = 1'b0; a_short = 3'd3; b_short = 3'd4; op_ab = 4'd1; go_btn = 1'b1;
    tick(11);
    check("rst_go_rise", go, 1);
    check("rst_go_op", op_code, 11'b00000000010);
`ifdef INPUT_COND_OP_ERR_EN
    check("legal_err", op_err, 0);
`endif
    reset = 1'b0;
    #1;
    check("rst_hs_go", go, 0);
    check("rst_hs_a", a, 0);
    check("rst_hs_b", b, 0);
    check("rst_hs_op", op_code, 0);
    go_btn = 1'b0;
    tick(2);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (go) pulses++;
    end
    check("rst_hs_quiet", pulses, 0);
    // randomized traffic
    pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) go_btn = ~go_btn;
      a_short   = 3'($urandom);
      b_short   = 3'($urandom);
      op_ab     = 4'($urandom);
      alu_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
      end
      tick(1);
      if (go) pulses++;
    end
    check("rand_activity", pulses > 0, 1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
